// File: rtl/ahb_mem_arbiter.sv
// Two-requester arbiter for the edge detector's single memory master port.
// One transfer in flight, bounded-burst round-robin, stop gating and hready timeout.
module ahb_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int BURST_LEN   = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              stop,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] haddr,
  output logic              hwrite,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);
  localparam logic [TMO_W-1:0] TMO_LAST  = (TIMEOUT_CYC > 0) ? TMO_W'(TIMEOUT_CYC - 1) : {TMO_W{1'b0}};
  localparam logic TMO_EN = (TIMEOUT_CYC > 0);

  localparam logic OWNER_RD = 1'b0;
  localparam logic OWNER_WR = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_BUS = 2'd1,
    WR_BUS = 2'd2,
    ACK    = 2'd3
  } state_t;

  state_t             state_r;
  logic               last_grant_r;
  logic [CNT_W-1:0]   burst_cnt_r;
  logic [TMO_W-1:0]   tmo_cnt_r;

  logic               grant_s;
  logic               grant_wr_s;
  logic               keep_s;
  logic [CNT_W-1:0]   next_cnt_s;
  logic               timeout_hit_s;

  // Grant decision for the IDLE edge, next burst count and timeout detect.
  // A zero burst count only exists after reset and means "no owner yet", so a tie goes to read.
  always_comb begin
    grant_s       = 1'b0;
    grant_wr_s    = OWNER_RD;
    keep_s        = (burst_cnt_r != {CNT_W{1'b0}}) && (burst_cnt_r < BURST_MAX);
    timeout_hit_s = TMO_EN && (tmo_cnt_r == TMO_LAST);
    if (!stop && rd_req && wr_req) begin
      grant_s    = 1'b1;
      grant_wr_s = keep_s ? last_grant_r : ~last_grant_r;
    end else if (!stop && rd_req) begin
      grant_s    = 1'b1;
      grant_wr_s = OWNER_RD;
    end else if (!stop && wr_req) begin
      grant_s    = 1'b1;
      grant_wr_s = OWNER_WR;
    end else begin
      grant_s    = 1'b0;
      grant_wr_s = OWNER_RD;
    end
    if (grant_wr_s == last_grant_r) begin
      next_cnt_s = (burst_cnt_r < BURST_MAX) ? (burst_cnt_r + CNT_W'(1)) : burst_cnt_r;
    end else begin
      next_cnt_s = CNT_W'(1);
    end
  end

  // Transfer FSM with all bus and requester outputs registered.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r      <= IDLE;
      last_grant_r <= OWNER_WR;
      burst_cnt_r  <= {CNT_W{1'b0}};
      tmo_cnt_r    <= {TMO_W{1'b0}};
      haddr        <= {ADDR_W{1'b0}};
      hwdata       <= {DATA_W{1'b0}};
      hwrite       <= 1'b0;
      rd_data      <= {DATA_W{1'b0}};
      rd_valid     <= 1'b0;
      wr_ack       <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_s) begin
            last_grant_r <= grant_wr_s;
            burst_cnt_r  <= next_cnt_s;
            tmo_cnt_r    <= {TMO_W{1'b0}};
            busy         <= 1'b1;
            if (grant_wr_s == OWNER_WR) begin
              haddr   <= wr_addr;
              hwdata  <= wr_data;
              hwrite  <= 1'b1;
              state_r <= WR_BUS;
            end else begin
              haddr   <= rd_addr;
              hwrite  <= 1'b0;
              state_r <= RD_BUS;
            end
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        RD_BUS: begin
          if (hready) begin
            rd_data  <= hrdata;
            rd_valid <= 1'b1;
            state_r  <= ACK;
          end else if (timeout_hit_s) begin
            rd_data     <= {DATA_W{1'b0}};
            rd_valid    <= 1'b1;
            timeout_err <= 1'b1;
            state_r     <= ACK;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          end
        end
        WR_BUS: begin
          if (hready) begin
            wr_ack  <= 1'b1;
            hwrite  <= 1'b0;
            state_r <= ACK;
          end else if (timeout_hit_s) begin
            wr_ack      <= 1'b1;
            hwrite      <= 1'b0;
            timeout_err <= 1'b1;
            state_r     <= ACK;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          end
        end
        ACK: begin
          rd_valid <= 1'b0;
          wr_ack   <= 1'b0;
          busy     <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          rd_valid <= 1'b0;
          wr_ack   <= 1'b0;
          hwrite   <= 1'b0;
          busy     <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule
